shot_controller: RTL and testbench
==================================

// Module: shot_controller
// PURPOSE
//  Sequences the player's trigger for each duck round. Edge-detects the trigger and holds one pending shot.
//  Fires that shot on the next frame tick during the FLY game state, then runs the registered hit test.
//  Counts shots remaining per duck and times the post-shot screen flash.
//  Sits between the gun/mouse input, the cursor renderer and the game-state FSM; drives bird_shot and no_shots_left.
// PARAMETERS
//  SHOTS_PER_DUCK  3      shots reloaded at each round_start (1..3)
//  DUCK_OFFSET     10'd32 added to duck_x/duck_y to get the duck sprite centre
//  HIT_HALF        32     hit window half-width in pixels, inclusive, both axes
//  FLASH_FRAMES    2      frame ticks flash stays high after every shot
//  FLY_STATE       3'b010 game-state code in which shots are allowed
// PORTS
//  Clk            in   1   50 MHz system clock
//  Reset          in   1   asynchronous, active-high reset
//  frame_clk      in   1   ~60 Hz frame strobe; its rising edge is the frame tick
//  shot           in   1   raw trigger level, synchronous to Clk
//  round_start    in   1   1-cycle pulse: new duck spawned; reload shots
//  state          in   3   game-FSM state
//  cursor_x/_y    in   10  cursor position, pixels
//  duck_x/_y      in   10  duck sprite top-left, pixels
//  shot_fired     out  1   1-cycle pulse per shot consumed
//  bird_shot      out  1   1-cycle pulse on hit
//  flash          out  1   level; high during flash interval
//  shots_left     out  2   remaining shots
//  no_shots_left  out  1   level; high in EMPTY
// BEHAVIOUR
//  Reset (async): FSM=IDLE; shots_left=0; no_shots_left=0; all pulses, flash, pend and edge regs = 0.
//  Edge detect: shot_q<=shot; a cycle where shot & ~shot_q sets pend. Holding the trigger gives one shot only.
//  Frame tick: fc_q<=frame_clk; tick = frame_clk & ~fc_q (combinational, 1 Clk cycle).
//  pend is cleared when a shot is consumed, on round_start, and on any cycle with state!=FLY_STATE.
//  A second edge while pend=1 is dropped.
//  FSM states:
//   IDLE   wait for round_start -> ARMED.
//   ARMED  on tick & pend & state==FLY_STATE & shots_left!=0:
//          - latch cursor/duck coords
//          - shots_left-=1, clear pend, go EVAL
//          - shot_fired=1 during the EVAL cycle
//   EVAL   exactly 1 cycle; the hit test uses the latched coords:
//          - rx = (duck_x+DUCK_OFFSET) - cursor_x, 12-bit signed with zero-extended operands; ry likewise
//          - hit = (-HIT_HALF<=rx<=HIT_HALF) && (-HIT_HALF<=ry<=HIT_HALF)
//          - latch hit, go FLASH
//   FLASH  flash=1; bird_shot=1 in the first FLASH cycle iff hit.
//          After FLASH_FRAMES ticks, flash=0 and exit:
//          - hit -> IDLE
//          - miss & shots_left==0 -> EMPTY
//          - otherwise -> ARMED
//          Edges during FLASH still set pend; that pend fires in ARMED on a later tick.
//   EMPTY  no_shots_left=1; hold until round_start.
//  round_start has top priority in every state, including EVAL and FLASH:
//   - shots_left=SHOTS_PER_DUCK, pend=0, flash=0, no_shots_left=0, go ARMED
//   - a bird_shot due that cycle is suppressed
//  shots_left never underflows; at 0 no shot is fired.
//  Latency: tick cycle t -> shot_fired at t+1 -> bird_shot at t+2.
//  Reset mid-FLASH: flash deasserts immediately.
// TESTING
//  1 round_start; cursor=(352,272), duck=(320,240); edge, then tick
//    -> shot_fired 1 cycle later; bird_shot 1 cycle after that; shots_left=2; FSM ends in IDLE.
//  2 cursor=(400,240), duck=(320,240) (rx=-48)
//    -> shot_fired, no bird_shot; flash high for 2 ticks; back to ARMED.
//  3 three misses -> shots_left 2,1,0; no_shots_left=1 after 3rd flash; 4th edge+tick -> no shot_fired.
//  4 hold shot high across 5 ticks -> exactly one shot_fired.
//    Edge with state=3'b001, then state=FLY and a tick -> no shot (pend was cleared).
//  5 Boundaries: rx=+32 -> hit, rx=-32 -> hit, rx=-33 -> miss.
//    round_start in same cycle as EVAL -> no bird_shot, shots_left=3.
//    Reset asserted mid-FLASH -> flash=0 and shots_left=0 without a clock edge.

Source files
------------

// File: rtl/shot_controller.sv
// ============================================================================
// Module: shot_controller
// ----------------------------------------------------------------------------
// Purpose:
//   Sequences the player's trigger for each duck round. The raw trigger is
//   edge-detected into a single pending shot. That shot fires on the next
//   frame tick while the game FSM is in its FLY state. The shot then runs a
//   registered hit test against the duck sprite centre. The block also
//   counts the shots remaining for the current duck and times the
//   post-shot screen flash.
//
// Ports:
//   Clk            in   1   system clock
//   Reset          in   1   asynchronous, active-high reset
//   frame_clk      in   1   frame strobe; its rising edge is the frame tick
//   shot           in   1   raw trigger level, synchronous to Clk
//   round_start    in   1   one-cycle pulse: new duck, reload shots
//   state          in   3   game-FSM state code
//   cursor_x/_y    in   10  cursor position in pixels
//   duck_x/_y      in   10  duck sprite top-left in pixels
//   shot_fired     out  1   one-cycle pulse per shot consumed
//   bird_shot      out  1   one-cycle pulse on a hit
//   flash          out  1   high during the post-shot flash interval
//   shots_left     out  2   shots remaining for this duck
//   no_shots_left  out  1   high while the duck can no longer be shot
// ============================================================================
module shot_controller #(
    parameter int         SHOTS_PER_DUCK = 3,
    parameter logic [9:0] DUCK_OFFSET    = 10'd32,
    parameter int         HIT_HALF       = 32,
    parameter int         FLASH_FRAMES   = 2,
    parameter logic [2:0] FLY_STATE      = 3'b010
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       shot,
    input  logic       round_start,
    input  logic [2:0] state,
    input  logic [9:0] cursor_x,
    input  logic [9:0] cursor_y,
    input  logic [9:0] duck_x,
    input  logic [9:0] duck_y,
    output logic       shot_fired,
    output logic       bird_shot,
    output logic       flash,
    output logic [1:0] shots_left,
    output logic       no_shots_left
);

    localparam logic [1:0]         LP_SHOTS      = 2'(SHOTS_PER_DUCK);
    localparam logic [7:0]         LP_FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic signed [11:0] LP_HALF_POS   = 12'(HIT_HALF);
    localparam logic signed [11:0] LP_HALF_NEG   = 12'(-HIT_HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_EVAL,
        S_FLASH,
        S_EMPTY
    } fsm_t;

    fsm_t r_fsm;

    logic       r_shot_q;
    logic       r_fc_q;
    logic       r_pend;
    logic       r_hit;
    logic [1:0] r_shots_left;
    logic       r_shot_fired;
    logic       r_bird_shot;
    logic       r_flash;
    logic       r_no_shots_left;
    logic [7:0] r_flash_cnt;
    logic [9:0] r_cursor_x;
    logic [9:0] r_cursor_y;
    logic [9:0] r_duck_x;
    logic [9:0] r_duck_y;

    logic               w_shot_edge;
    logic               w_tick;
    logic               w_in_fly;
    logic               w_fire;
    logic [11:0]        w_duck_cx;
    logic [11:0]        w_duck_cy;
    logic signed [11:0] w_rx;
    logic signed [11:0] w_ry;
    logic               w_hit;

    assign w_shot_edge = shot & ~r_shot_q;
    assign w_tick      = frame_clk & ~r_fc_q;
    assign w_in_fly    = (state == FLY_STATE);

    // A shot is consumed only when everything lines up on a frame tick.
    // round_start wins over a simultaneous fire so the reload is clean.
    assign w_fire = (r_fsm == S_ARMED) && w_tick && r_pend && w_in_fly &&
                    (r_shots_left != 2'd0) && !round_start;

    // Operands are zero-extended to 12 bits so the signed difference
    // cannot wrap for any 10-bit screen coordinate.
    assign w_duck_cx = {2'b00, r_duck_x} + {2'b00, DUCK_OFFSET};
    assign w_duck_cy = {2'b00, r_duck_y} + {2'b00, DUCK_OFFSET};
    assign w_rx      = $signed(w_duck_cx - {2'b00, r_cursor_x});
    assign w_ry      = $signed(w_duck_cy - {2'b00, r_cursor_y});
    assign w_hit     = (w_rx >= LP_HALF_NEG) && (w_rx <= LP_HALF_POS) &&
                       (w_ry >= LP_HALF_NEG) && (w_ry <= LP_HALF_POS);

    // Delayed copies of the trigger and the frame strobe. These feed the
    // rising-edge detectors.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_shot_q <= 1'b0;
            r_fc_q   <= 1'b0;
        end else begin
            r_shot_q <= shot;
            r_fc_q   <= frame_clk;
        end
    end

    // A single pending shot. Clearing has priority over setting, so an
    // edge outside FLY never survives. A second edge while pending is
    // simply absorbed.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pend <= 1'b0;
        end else if (round_start || !w_in_fly || w_fire) begin
            r_pend <= 1'b0;
        end else if (w_shot_edge) begin
            r_pend <= 1'b1;
        end
    end

    // Round sequencer with registered pulse and level outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fsm           <= S_IDLE;
            r_hit           <= 1'b0;
            r_shots_left    <= 2'd0;
            r_shot_fired    <= 1'b0;
            r_bird_shot     <= 1'b0;
            r_flash         <= 1'b0;
            r_no_shots_left <= 1'b0;
            r_flash_cnt     <= 8'd0;
            r_cursor_x      <= 10'd0;
            r_cursor_y      <= 10'd0;
            r_duck_x        <= 10'd0;
            r_duck_y        <= 10'd0;
        end else begin
            r_shot_fired <= 1'b0;
            r_bird_shot  <= 1'b0;
            if (round_start) begin
                r_fsm           <= S_ARMED;
                r_shots_left    <= LP_SHOTS;
                r_flash         <= 1'b0;
                r_no_shots_left <= 1'b0;
                r_flash_cnt     <= 8'd0;
            end else begin
                case (r_fsm)
                    S_IDLE: begin
                    end
                    S_ARMED: begin
                        if (w_fire) begin
                            r_cursor_x   <= cursor_x;
                            r_cursor_y   <= cursor_y;
                            r_duck_x     <= duck_x;
                            r_duck_y     <= duck_y;
                            r_shots_left <= r_shots_left - 2'd1;
                            r_shot_fired <= 1'b1;
                            r_fsm        <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        r_hit       <= w_hit;
                        r_bird_shot <= w_hit;
                        r_flash     <= 1'b1;
                        r_flash_cnt <= 8'd0;
                        r_fsm       <= S_FLASH;
                    end
                    S_FLASH: begin
                        if (w_tick) begin
                            if (r_flash_cnt == LP_FLASH_LAST) begin
                                r_flash <= 1'b0;
                                if (r_hit) begin
                                    r_fsm <= S_IDLE;
                                end else if (r_shots_left == 2'd0) begin
                                    r_fsm           <= S_EMPTY;
                                    r_no_shots_left <= 1'b1;
                                end else begin
                                    r_fsm <= S_ARMED;
                                end
                            end else begin
                                r_flash_cnt <= r_flash_cnt + 8'd1;
                            end
                        end
                    end
                    S_EMPTY: begin
                    end
                    default: begin
                        r_fsm <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign shot_fired    = r_shot_fired;
    assign bird_shot     = r_bird_shot;
    assign flash         = r_flash;
    assign shots_left    = r_shots_left;
    assign no_shots_left = r_no_shots_left;

endmodule

// File: tb/tb_shot_controller.sv
// ============================================================================
// Testbench: tb_shot_controller
// ----------------------------------------------------------------------------
// Directed scenarios for shot_controller. Inputs change on the falling edge
// of Clk, and outputs are sampled on the falling edge as well.
// ============================================================================
module tb_shot_controller;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       shot;
    logic       round_start;
    logic [2:0] state;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic [9:0] duck_x;
    logic [9:0] duck_y;
    logic       shot_fired;
    logic       bird_shot;
    logic       flash;
    logic [1:0] shots_left;
    logic       no_shots_left;

    int nChecks;
    int nFails;

    localparam logic [2:0] FLY = 3'b010;

    shot_controller dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .shot         (shot),
        .round_start  (round_start),
        .state        (state),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .duck_x       (duck_x),
        .duck_y       (duck_y),
        .shot_fired   (shot_fired),
        .bird_shot    (bird_shot),
        .flash        (flash),
        .shots_left   (shots_left),
        .no_shots_left(no_shots_left)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Safety net so the run always ends.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus helpers
    task automatic start_round();
        round_start = 1'b1;
        @(negedge Clk);
        round_start = 1'b0;
    endtask

    task automatic set_coords(input logic [9:0] cx, input logic [9:0] cy,
                              input logic [9:0] dx, input logic [9:0] dy);
        cursor_x = cx;
        cursor_y = cy;
        duck_x   = dx;
        duck_y   = dy;
    endtask

    task automatic trigger_edge();
        shot = 1'b1;
        @(negedge Clk);
        shot = 1'b0;
        @(negedge Clk);
    endtask

    // Raise frame_clk, then sample shot_fired one cycle later and
    // bird_shot one cycle after that.
    task automatic tick_observe(output logic fired, output logic bird);
        frame_clk = 1'b1;
        @(negedge Clk);
        fired = shot_fired;
        frame_clk = 1'b0;
        @(negedge Clk);
        bird = bird_shot;
    endtask

    task automatic plain_tick();
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    // Scenarios
    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        nChecks++; if (shots_left !== 2'd0) begin nFails++; $display("[TB] FAIL reset_shots_left: got %0d, expected 0", shots_left); end
        nChecks++; if (flash !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flash: got %0b, expected 0", flash); end
        nChecks++; if (no_shots_left !== 1'b0) begin nFails++; $display("[TB] FAIL reset_no_shots_left: got %0b, expected 0", no_shots_left); end
        nChecks++; if ({shot_fired, bird_shot} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_pulses: got %b, expected 00", {shot_fired, bird_shot}); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_hit();
        logic f, b;
        set_coords(10'd352, 10'd272, 10'd320, 10'd240);
        start_round();
        nChecks++; if (shots_left !== 2'd3) begin nFails++; $display("[TB] FAIL hit_reload: got %0d, expected 3", shots_left); end
        trigger_edge();
        tick_observe(f, b);
        nChecks++; if (f !== 1'b1) begin nFails++; $display("[TB] FAIL hit_shot_fired: got %0b, expected 1", f); end
        nChecks++; if (b !== 1'b1) begin nFails++; $display("[TB] FAIL hit_bird_shot: got %0b, expected 1", b); end
        nChecks++; if (shots_left !== 2'd2) begin nFails++; $display("[TB] FAIL hit_shots_left: got %0d, expected 2", shots_left); end
        @(negedge Clk);
        nChecks++; if (bird_shot !== 1'b0) begin nFails++; $display("[TB] FAIL hit_bird_pulse_width: got %0b, expected 0", bird_shot); end
        plain_tick();
        plain_tick();
        nChecks++; if (flash !== 1'b0) begin nFails++; $display("[TB] FAIL hit_flash_end: got %0b, expected 0", flash); end
        // After a hit the FSM idles, so a fresh trigger must not fire.
        trigger_edge();
        tick_observe(f, b);
        nChecks++; if (f !== 1'b0) begin nFails++; $display("[TB] FAIL hit_idle_no_fire: got %0b, expected 0", f); end
        nChecks++; if (shots_left !== 2'd2) begin nFails++; $display("[TB] FAIL hit_idle_shots: got %0d, expected 2", shots_left); end
    endtask

    task automatic test_miss();
        logic f, b;
        set_coords(10'd400, 10'd240, 10'd320, 10'd240);
        start_round();
        trigger_edge();
        tick_observe(f, b);
        nChecks++; if (f !== 1'b1) begin nFails++; $display("[TB] FAIL miss_shot_fired: got %0b, expected 1", f); end
        nChecks++; if (b !== 1'b0) begin nFails++; $display("[TB] FAIL miss_bird_shot: got %0b, expected 0", b); end
        nChecks++; if (flash !== 1'b1) begin nFails++; $display("[TB] FAIL miss_flash_on: got %0b, expected 1", flash); end
        plain_tick();
        nChecks++; if (flash !== 1'b1) begin nFails++; $display("[TB] FAIL miss_flash_after_1_tick: got %0b, expected 1", flash); end
        plain_tick();
        nChecks++; if (flash !== 1'b0) begin nFails++; $display("[TB] FAIL miss_flash_after_2_ticks: got %0b, expected 0", flash); end
        nChecks++; if (no_shots_left !== 1'b0) begin nFails++; $display("[TB] FAIL miss_not_empty: got %0b, expected 0", no_shots_left); end
    endtask

    // Continues from test_miss with two shots left.
    task automatic test_empty();
        logic f, b;
        trigger_edge();
        tick_observe(f, b);
        nChecks++; if (f !== 1'b1 || shots_left !== 2'd1) begin nFails++; $display("[TB] FAIL empty_second_shot: got fired=%0b left=%0d, expected fired=1 left=1", f, shots_left); end
        plain_tick();
        plain_tick();
        trigger_edge();
        tick_observe(f, b);
        nChecks++; if (f !== 1'b1 || shots_left !== 2'd0) begin nFails++; $display("[TB] FAIL empty_third_shot: got fired=%0b left=%0d, expected fired=1 left=0", f, shots_left); end
        nChecks++; if (no_shots_left !== 1'b0) begin nFails++; $display("[TB] FAIL empty_during_flash: got %0b, expected 0", no_shots_left); end
        plain_tick();
        plain_tick();
        nChecks++; if (no_shots_left !== 1'b1) begin nFails++; $display("[TB] FAIL empty_no_shots_left: got %0b, expected 1", no_shots_left); end
        trigger_edge();
        tick_observe(f, b);
        nChecks++; if (f !== 1'b0 || shots_left !== 2'd0) begin nFails++; $display("[TB] FAIL empty_fourth_shot: got fired=%0b left=%0d, expected fired=0 left=0", f, shots_left); end
    endtask

    task automatic test_hold();
        logic f, b;
        int fires;
        set_coords(10'd400, 10'd240, 10'd320, 10'd240);
        start_round();
        fires = 0;
        shot = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            frame_clk = 1'b1;
            @(negedge Clk);
            if (shot_fired === 1'b1) fires++;
            frame_clk = 1'b0;
            @(negedge Clk);
            if (shot_fired === 1'b1) fires++;
        end
        nChecks++; if (fires != 1) begin nFails++; $display("[TB] FAIL hold_single_shot: got %0d shots, expected 1", fires); end
        nChecks++; if (shots_left !== 2'd2) begin nFails++; $display("[TB] FAIL hold_shots_left: got %0d, expected 2", shots_left); end
        shot = 1'b0;
        @(negedge Clk);
        // The edge arrives outside FLY, so its pending shot is discarded.
        state = 3'b001;
        shot  = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        state = FLY;
        @(negedge Clk);
        tick_observe(f, b);
        nChecks++; if (f !== 1'b0) begin nFails++; $display("[TB] FAIL nonfly_edge_dropped: got %0b, expected 0", f); end
        shot = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_one_shot(input string name,
                                 input logic [9:0] cx, input logic [9:0] cy,
                                 input logic [9:0] dx, input logic [9:0] dy,
                                 input logic expHit);
        logic f, b;
        set_coords(cx, cy, dx, dy);
        start_round();
        trigger_edge();
        tick_observe(f, b);
        nChecks++; if (f !== 1'b1 || b !== expHit) begin nFails++; $display("[TB] FAIL %s: got fired=%0b hit=%0b, expected fired=1 hit=%0b", name, f, b, expHit); end
        plain_tick();
        plain_tick();
    endtask

    task automatic test_boundaries();
        test_one_shot("rx_plus_32_hit",   10'd320, 10'd352, 10'd320, 10'd320, 1'b1);
        test_one_shot("rx_minus_32_hit",  10'd384, 10'd352, 10'd320, 10'd320, 1'b1);
        test_one_shot("rx_minus_33_miss", 10'd385, 10'd352, 10'd320, 10'd320, 1'b0);
        test_one_shot("ry_plus_33_miss",  10'd352, 10'd319, 10'd320, 10'd320, 1'b0);
    endtask

    task automatic test_round_start_eval();
        set_coords(10'd352, 10'd272, 10'd320, 10'd240);
        start_round();
        trigger_edge();
        frame_clk = 1'b1;
        @(negedge Clk);
        nChecks++; if (shot_fired !== 1'b1) begin nFails++; $display("[TB] FAIL rs_eval_in_eval: got %0b, expected 1", shot_fired); end
        frame_clk   = 1'b0;
        round_start = 1'b1;
        @(negedge Clk);
        round_start = 1'b0;
        nChecks++; if (bird_shot !== 1'b0) begin nFails++; $display("[TB] FAIL rs_eval_bird_suppressed: got %0b, expected 0", bird_shot); end
        nChecks++; if (shots_left !== 2'd3) begin nFails++; $display("[TB] FAIL rs_eval_reload: got %0d, expected 3", shots_left); end
        nChecks++; if (flash !== 1'b0) begin nFails++; $display("[TB] FAIL rs_eval_flash: got %0b, expected 0", flash); end
    endtask

    task automatic test_reset_flash();
        logic f, b;
        set_coords(10'd400, 10'd240, 10'd320, 10'd240);
        start_round();
        trigger_edge();
        tick_observe(f, b);
        nChecks++; if (flash !== 1'b1) begin nFails++; $display("[TB] FAIL rst_flash_before: got %0b, expected 1", flash); end
        #2;
        Reset = 1'b1;
        #1;
        nChecks++; if (flash !== 1'b0) begin nFails++; $display("[TB] FAIL rst_flash_async: got %0b, expected 0", flash); end
        nChecks++; if (shots_left !== 2'd0) begin nFails++; $display("[TB] FAIL rst_shots_async: got %0d, expected 0", shots_left); end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        nChecks     = 0;
        nFails      = 0;
        Reset       = 1'b1;
        frame_clk   = 1'b0;
        shot        = 1'b0;
        round_start = 1'b0;
        state       = FLY;
        set_coords(10'd0, 10'd0, 10'd0, 10'd0);
        test_reset();
        test_hit();
        test_miss();
        test_empty();
        test_hold();
        test_boundaries();
        test_round_start_eval();
        test_reset_flash();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
